// File: rtl/nandy_pkg.sv
// Shared types and helpers for the index decode / encode block family.
package nandy_pkg;

  localparam int IDX_W_DEF = 4;
  // popcount is sized for the widest supported index (IDX_W <= 8).
  localparam int MAX_IDX_W = 8;
  localparam int MAX_OUT_W = 1 << MAX_IDX_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } state_t;

  function automatic logic [MAX_IDX_W:0] popcount(input logic [MAX_OUT_W-1:0] v);
    logic [MAX_IDX_W:0] c;
    c = '0;
    for (int i = 0; i < MAX_OUT_W; i++) begin
      c = c + {{MAX_IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/index_decoder_stream_onehot_decode.sv
// Combinational binary index to one-hot decoder; all-zero when disabled.
module onehot_decode #(
  parameter int IDX_W = 4
) (
  input  logic                    i_en,
  input  logic [IDX_W-1:0]        i_idx,
  output logic [(1<<IDX_W)-1:0]   o_oh
);

  localparam int OUT_W = 1 << IDX_W;

  assign o_oh = i_en ? (OUT_W'(1) << i_idx) : '0;

endmodule

// File: rtl/index_decoder_stream.sv
// Streaming index-to-one-hot decoder with optional OR-accumulation over frames
// closed by in_last; single registered output stage with valid/ready.
module index_decoder_stream
  import nandy_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int ACCUM = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic                    in_en,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<IDX_W)-1:0]   out_vec,
  output logic [IDX_W:0]          out_count,
  output logic                    out_dup
);

  localparam int OUT_W = 1 << IDX_W;

  state_t             r_state;
  logic [OUT_W-1:0]   r_acc;
  logic               r_dup;
  logic               r_vld_p1;
  logic [OUT_W-1:0]   r_vec_p1;
  logic [IDX_W:0]     r_cnt_p1;
  logic               r_dup_p1;

  logic [OUT_W-1:0]   w_oh;
  logic [OUT_W-1:0]   w_base;
  logic [OUT_W-1:0]   w_merge;
  logic               w_hit;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_emit;

  onehot_decode #(.IDX_W(IDX_W)) u_dec (
    .i_en  (in_en),
    .i_idx (in_idx),
    .o_oh  (w_oh)
  );

  // The accumulator only contributes while a frame is open; in per-beat mode
  // it never leaves S_IDLE, so every beat decodes on its own.
  assign w_base     = (r_state == S_FRAME) ? r_acc : '0;
  assign w_merge    = w_base | w_oh;
  assign w_hit      = |(w_base & w_oh);
  assign w_in_ready = !r_vld_p1 || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_emit     = w_accept && ((ACCUM == 0) || in_last);

  // Stage p0 -> p1: frame state, accumulator and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_dup    <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vec_p1 <= '0;
      r_cnt_p1 <= '0;
      r_dup_p1 <= 1'b0;
    end else begin
      if (w_emit) begin
        r_vld_p1 <= 1'b1;
        r_vec_p1 <= w_merge;
        r_cnt_p1 <= (IDX_W+1)'(popcount(MAX_OUT_W'(w_merge)));
        r_dup_p1 <= (r_state == S_FRAME) && (r_dup || w_hit);
      end else if (out_ready) begin
        r_vld_p1 <= 1'b0;
      end

      if (w_accept && (ACCUM != 0)) begin
        case (r_state)
          S_IDLE: begin
            if (!in_last) begin
              r_state <= S_FRAME;
              r_acc   <= w_oh;
              r_dup   <= 1'b0;
            end
          end
          S_FRAME: begin
            if (in_last) begin
              r_state <= S_IDLE;
              r_acc   <= '0;
              r_dup   <= 1'b0;
            end else begin
              r_acc   <= w_merge;
              r_dup   <= r_dup | w_hit;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_vld_p1;
  assign out_vec   = r_vec_p1;
  assign out_count = r_cnt_p1;
  assign out_dup   = r_dup_p1;

endmodule
